// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter : core/loader arbiter for the shared instruction/data memory
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MAXWAIT = 8,
   parameter int MAXLOCK = 16
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_stall,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,

   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   input  logic          l_lock,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,

   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,

   output logic [1:0]    owner,
   output logic          lock_timeout
);

   localparam int WW = $clog2(MAXWAIT + 1);
   localparam int LW = $clog2(MAXLOCK + 1);

   localparam logic [WW-1:0] C_WMAX  = WW'(MAXWAIT);
   localparam logic [WW-1:0] C_WONE  = WW'(1);
   localparam logic [LW-1:0] C_LLAST = LW'(MAXLOCK - 1);
   localparam logic [LW-1:0] C_LONE  = LW'(1);

   typedef enum logic [1:0] {
      ARB     = 2'd0,
      LOCK    = 2'd1,
      INHIBIT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          lock_timeout_q, lock_timeout_d;
   logic          c_rvalid_q, c_rvalid_d;
   logic          l_rvalid_q, l_rvalid_d;
   logic [DW-1:0] c_rdata_q, c_rdata_d;
   logic [DW-1:0] l_rdata_q, l_rdata_d;

   // Grants are forced low while reset is asserted so no access leaks out.
   always_comb begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!reset) begin
         if (state_q == LOCK) begin
            l_gnt = l_req;
         end else if (l_req && (!c_req || wcnt_q == C_WMAX)) begin
            l_gnt = 1'b1;
         end else begin
            c_gnt = c_req;
         end
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (c_gnt) begin
         mem_we    = c_we;
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
      end else if (l_gnt) begin
         mem_we    = l_we;
         mem_addr  = l_addr;
         mem_wdata = l_wdata;
      end
   end

   assign owner        = {l_gnt, c_gnt};
   assign c_stall      = c_req & ~c_gnt & ~reset;
   assign c_rvalid     = c_rvalid_q;
   assign c_rdata      = c_rdata_q;
   assign l_rvalid     = l_rvalid_q;
   assign l_rdata      = l_rdata_q;
   assign lock_timeout = lock_timeout_q;

   always_comb begin
      state_d        = state_q;
      lcnt_d         = lcnt_q;
      lock_timeout_d = lock_timeout_q;

      if (l_req && !l_gnt) begin
         wcnt_d = (wcnt_q == C_WMAX) ? wcnt_q : wcnt_q + C_WONE;
      end else begin
         wcnt_d = '0;
      end

      case (state_q)
         ARB: begin
            if (l_gnt && l_lock) begin
               state_d = LOCK;
               lcnt_d  = '0;
            end
         end
         LOCK: begin
            lcnt_d = lcnt_q + C_LONE;
            if (!l_lock) begin
               state_d = ARB;
            end else if (lcnt_q == C_LLAST) begin
               state_d        = INHIBIT;
               lock_timeout_d = 1'b1;
            end
         end
         INHIBIT: begin
            if (!l_lock) begin
               state_d = ARB;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase

      c_rvalid_d = c_gnt & ~c_we;
      l_rvalid_d = l_gnt & ~l_we;
      c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
      l_rdata_d  = l_rvalid_d ? mem_rdata : l_rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ARB;
         wcnt_q         <= '0;
         lcnt_q         <= '0;
         lock_timeout_q <= 1'b0;
         c_rvalid_q     <= 1'b0;
         l_rvalid_q     <= 1'b0;
         c_rdata_q      <= '0;
         l_rdata_q      <= '0;
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         lcnt_q         <= lcnt_d;
         lock_timeout_q <= lock_timeout_d;
         c_rvalid_q     <= c_rvalid_d;
         l_rvalid_q     <= l_rvalid_d;
         c_rdata_q      <= c_rdata_d;
         l_rdata_q      <= l_rdata_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter : bench for mem_port_arbiter (MAXWAIT=4, MAXLOCK=8)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int MAXWAIT = 4;
   localparam int MAXLOCK = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          c_req, c_we, c_gnt, c_stall, c_rvalid;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata, c_rdata;
   logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata, l_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [1:0]    owner;
   logic          lock_timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .MAXWAIT(MAXWAIT), .MAXLOCK(MAXLOCK)
   ) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner), .lock_timeout(lock_timeout)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return (32'(i) * 32'h01010101) ^ 32'hA5000000;
   endfunction

   // Single-ported memory with combinational read
   logic [DW-1:0] mem [0:255];
   logic          mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[9:2]];

   // Reference model: mode 0 = free, 1 = locked, 2 = lock expired
   logic [31:0] mmem [0:255];
   int          m_mode, m_denied, m_lock_used;
   bit          m_timeout, m_crv, m_lrv, exp_cg, exp_lg;
   logic [31:0] m_crd, m_lrd;

   function automatic void model_reset();
      m_mode = 0; m_denied = 0; m_lock_used = 0; m_timeout = 1'b0;
      m_crv = 1'b0; m_lrv = 1'b0; m_crd = '0; m_lrd = '0;
   endfunction

   function automatic void model_decide();
      if (m_mode == 1) begin
         exp_lg = l_req;
         exp_cg = 1'b0;
      end else begin
         exp_lg = l_req && (!c_req || m_denied >= MAXWAIT);
         exp_cg = c_req && !exp_lg;
      end
   endfunction

   function automatic void model_commit();
      m_crv = exp_cg && !c_we;
      m_lrv = exp_lg && !l_we;
      if (m_crv) m_crd = mmem[c_addr[9:2]];
      if (m_lrv) m_lrd = mmem[l_addr[9:2]];
      if (exp_cg && c_we) mmem[c_addr[9:2]] = c_wdata;
      if (exp_lg && l_we) mmem[l_addr[9:2]] = l_wdata;
      if (l_req && !exp_lg) m_denied = (m_denied < MAXWAIT) ? m_denied + 1 : MAXWAIT;
      else                  m_denied = 0;
      case (m_mode)
         0: if (exp_lg && l_lock) begin m_mode = 1; m_lock_used = 0; end
         1: begin
            if (!l_lock) m_mode = 0;
            else begin
               m_lock_used++;
               if (m_lock_used == MAXLOCK) begin m_mode = 2; m_timeout = 1'b1; end
            end
         end
         default: if (!l_lock) m_mode = 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Called just after the negedge that drove new inputs.
   task automatic check_model(input string tag);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      #1;
      model_decide();
      ea = exp_cg ? c_addr : (exp_lg ? l_addr : '0);
      ed = exp_cg ? c_wdata : (exp_lg ? l_wdata : '0);
      chk({tag, " c_gnt"},     64'(c_gnt),     64'(exp_cg));
      chk({tag, " l_gnt"},     64'(l_gnt),     64'(exp_lg));
      chk({tag, " c_stall"},   64'(c_stall),   64'(c_req && !exp_cg));
      chk({tag, " owner"},     64'(owner),     64'({exp_lg, exp_cg}));
      chk({tag, " mem_we"},    64'(mem_we),    64'((exp_cg && c_we) || (exp_lg && l_we)));
      chk({tag, " mem_addr"},  64'(mem_addr),  64'(ea));
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(ed));
      chk({tag, " c_rvalid"},  64'(c_rvalid),  64'(m_crv));
      chk({tag, " c_rdata"},   64'(c_rdata),   64'(m_crd));
      chk({tag, " l_rvalid"},  64'(l_rvalid),  64'(m_lrv));
      chk({tag, " l_rdata"},   64'(l_rdata),   64'(m_lrd));
      chk({tag, " lock_to"},   64'(lock_timeout), 64'(m_timeout));
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   // Directed vectors; ex = {c_gnt, l_gnt, c_stall, owner[1:0], mem_we, c_rvalid, l_rvalid}
   typedef struct {
      bit [4:0]    in;   // {c_req, c_we, l_req, l_we, l_lock}
      logic [31:0] ca, la, wd;
      bit [7:0]    ex;
      bit          tmo;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input int n, input bit [4:0] in, input logic [31:0] ca,
                               input logic [31:0] la, input logic [31:0] wd,
                               input bit [7:0] ex, input bit tmo);
      vec_t v;
      v.in = in; v.ca = ca; v.la = la; v.wd = wd; v.ex = ex; v.tmo = tmo;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
      model_reset();

      // core read, then idle for read return
      add(1, 5'b10000, 32'h10, 32'h0,  32'h0,        8'b1_0_0_01_0_0_0, 1'b0);
      add(1, 5'b00000, 32'h0,  32'h0,  32'h0,        8'b0_0_0_00_0_1_0, 1'b0);
      // starvation bound: core writes, loader reads
      add(4, 5'b11100, 32'h20, 32'h10, 32'h11111111, 8'b1_0_0_01_1_0_0, 1'b0);
      add(1, 5'b11100, 32'h20, 32'h10, 32'h11111111, 8'b0_1_1_10_0_0_0, 1'b0);
      add(1, 5'b11100, 32'h20, 32'h10, 32'h11111111, 8'b1_0_0_01_1_0_1, 1'b0);
      add(3, 5'b11100, 32'h20, 32'h10, 32'h11111111, 8'b1_0_0_01_1_0_0, 1'b0);
      add(1, 5'b11100, 32'h20, 32'h10, 32'h11111111, 8'b0_1_1_10_0_0_0, 1'b0);
      add(1, 5'b00000, 32'h0,  32'h0,  32'h0,        8'b0_0_0_00_0_0_1, 1'b0);
      // locked burst
      add(1, 5'b00111, 32'h0,  32'h60, 32'h19,       8'b0_1_0_10_1_0_0, 1'b0);
      add(1, 5'b10111, 32'h68, 32'h64, 32'h19,       8'b0_1_1_10_1_0_0, 1'b0);
      add(1, 5'b10111, 32'h68, 32'h68, 32'h19,       8'b0_1_1_10_1_0_0, 1'b0);
      add(1, 5'b10000, 32'h68, 32'h0,  32'h0,        8'b0_0_1_00_0_0_0, 1'b0);
      add(1, 5'b10000, 32'h68, 32'h0,  32'h0,        8'b1_0_0_01_0_0_0, 1'b0);
      add(1, 5'b00000, 32'h0,  32'h0,  32'h0,        8'b0_0_0_00_0_1_0, 1'b0);
      // lock timeout, inhibit arbitration, return to ARB
      add(1, 5'b00111, 32'h0,  32'h70, 32'h5A5A,     8'b0_1_0_10_1_0_0, 1'b0);
      add(8, 5'b11111, 32'h24, 32'h70, 32'h5A5A,     8'b0_1_1_10_1_0_0, 1'b0);
      add(4, 5'b11111, 32'h24, 32'h70, 32'h5A5A,     8'b1_0_0_01_1_0_0, 1'b1);
      add(1, 5'b11111, 32'h24, 32'h70, 32'h5A5A,     8'b0_1_1_10_1_0_0, 1'b1);
      add(4, 5'b11111, 32'h24, 32'h70, 32'h5A5A,     8'b1_0_0_01_1_0_0, 1'b1);
      add(1, 5'b11110, 32'h24, 32'h70, 32'h5A5A,     8'b0_1_1_10_1_0_0, 1'b1);
      add(1, 5'b11000, 32'h24, 32'h0,  32'h5A5A,     8'b1_0_0_01_1_0_0, 1'b1);
      add(1, 5'b00111, 32'h0,  32'h74, 32'h5A5A,     8'b0_1_0_10_1_0_0, 1'b1);
      add(1, 5'b11001, 32'h24, 32'h0,  32'h5A5A,     8'b0_0_1_00_0_0_0, 1'b1);
      add(1, 5'b11000, 32'h24, 32'h0,  32'h5A5A,     8'b0_0_1_00_0_0_0, 1'b1);
      add(1, 5'b11000, 32'h24, 32'h0,  32'h5A5A,     8'b1_0_0_01_1_0_0, 1'b1);
      add(1, 5'b00000, 32'h0,  32'h0,  32'h0,        8'b0_0_0_00_0_0_0, 1'b1);

      // reset state with both requesters asking
      reset = 1'b1;
      {c_req, c_we, l_req, l_we, l_lock} = 5'b10100;
      c_addr = '0; l_addr = '0; c_wdata = '0; l_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset flags", 64'({c_gnt, l_gnt, c_stall, owner, mem_we, c_rvalid, l_rvalid}), 64'(0));
      chk("reset mem_addr", 64'(mem_addr), 64'(0));
      chk("reset rdata", 64'({c_rdata, l_rdata}), 64'(0));
      chk("reset lock_to", 64'(lock_timeout), 64'(0));
      @(negedge clk);
      {c_req, c_we, l_req, l_we, l_lock} = 5'b00000;
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         {c_req, c_we, l_req, l_we, l_lock} = tbl[i].in;
         c_addr = tbl[i].ca; l_addr = tbl[i].la;
         c_wdata = tbl[i].wd; l_wdata = tbl[i].wd;
         check_model($sformatf("vec%0d", i));
         chk($sformatf("vec%0d flags", i),
             64'({c_gnt, l_gnt, c_stall, owner, mem_we, c_rvalid, l_rvalid}), 64'(tbl[i].ex));
         chk($sformatf("vec%0d lock_timeout", i), 64'(lock_timeout), 64'(tbl[i].tmo));
         advance();
      end

      // reset pulsed while a core read is in flight
      {c_req, c_we, l_req, l_we, l_lock} = 5'b10000;
      c_addr = 32'h10;
      check_model("rst_pre");
      #1;
      reset = 1'b1;
      l_req = 1'b1;
      #1;
      chk("rst grants", 64'({c_gnt, l_gnt}), 64'(0));
      chk("rst c_stall", 64'(c_stall), 64'(0));
      chk("rst mem_we", 64'(mem_we), 64'(0));
      chk("rst owner", 64'(owner), 64'(0));
      @(posedge clk);
      #1;
      chk("rst c_rvalid", 64'(c_rvalid), 64'(0));
      chk("rst c_rdata", 64'(c_rdata), 64'(0));
      chk("rst lock_to", 64'(lock_timeout), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      l_req = 1'b0;
      model_reset();
      check_model("post_rst_read");
      advance();
      {c_req, c_we, l_req, l_we, l_lock} = 5'b00000;
      check_model("post_rst_idle");
      chk("post_rst c_rdata", 64'(c_rdata), 64'(32'hDEADBEEF));
      advance();

      // randomized traffic; a denied request is held until granted
      for (int n = 0; n < 3000; n++) begin
         if (!(c_req && !exp_cg)) begin
            c_req   = ($urandom_range(0, 3) != 0);
            c_we    = 1'($urandom_range(0, 1));
            c_addr  = AW'($urandom_range(0, 63)) << 2;
            c_wdata = $urandom;
         end
         if (!(l_req && !exp_lg)) begin
            l_req   = ($urandom_range(0, 1) != 0);
            l_we    = 1'($urandom_range(0, 1));
            l_addr  = AW'($urandom_range(0, 63)) << 2;
            l_wdata = $urandom;
         end
         if ($urandom_range(0, 15) == 0) l_lock = ~l_lock;
         check_model($sformatf("rnd%0d", n));
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
